imm_insert_encoder: RTL and testbench
=====================================

Name: imm_insert_encoder

Overview:
- Inverse of the immediate extender: takes a 32-bit immediate plus an immsrc type code and packs it into the scattered immediate bit positions of an RV32I instruction word.
- Non-immediate fields (opcode, rd, rs1, rs2, funct3, funct7) come from a base word.
- 2-stage valid/ready pipeline with a range/alignment checker and a saturating error counter.
- Used by the self-modifying-code test generator and the instruction-ROM builder path.

Parameters:
CNT_W, 16, width of err_count
CHECK_EN, 1, 1 = range/alignment checking active; 0 = out_err forced to 0 and err_count held at 0

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept input this cycle
in_immsrc  input  3  000 I, 001 S, 010 B, 011 J, 100 U
in_imm  input  32  immediate value, two's complement
in_base  input  32  instruction supplying all non-immediate bits
out_valid  output  1  encoded word valid
out_ready  input  1  downstream accepts
out_instr  output  32  encoded instruction
out_err  output  1  immediate not representable or immsrc illegal
err_count  output  CNT_W  count of errored words delivered

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset). Polarity and synchronicity are fixed.
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, out_instr=0, out_err=0, err_count=0.
- Reset mid-operation drops all in-flight words. They are never emitted.
- Handshake:
  - Transfer occurs when valid && ready.
  - s2_en = !s2_valid || out_ready; s1_en = !s1_valid || s2_en; in_ready = s1_en.
  - The ready path is combinational from out_ready.
  - Throughput is 1 word/cycle.
  - Latency is 2 cycles from input transfer to out_valid when not stalled.
  - Order is preserved. No word is dropped or duplicated under any backpressure pattern.
  - out_instr and out_err hold stable while out_valid && !out_ready.
- Stage 1:
  - Registers in_immsrc, in_imm, in_base.
  - Computes err1 (CHECK_EN=1):
    - I, S: err if imm[31:11] not all equal.
    - B: err if imm[0]!=0 or imm[31:12] not all equal.
    - J: err if imm[0]!=0 or imm[31:20] not all equal.
    - U: err if imm[11:0]!=0.
    - 101/110/111: always err.
- Stage 2 packing: start from base, then overwrite the immediate positions:
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
  - U: [31:12]=imm[31:12]
  - Illegal immsrc: out_instr = base unchanged.
- Errored words are still emitted with truncated bits packed and out_err=1. The block never blocks on error.
- err_count:
  - Increments by 1 on an output transfer with out_err=1.
  - Saturates at all-ones and never wraps.
  - Increments regardless of the input-side transfer in the same cycle.
- Simultaneous input accept and output transfer in the same cycle is legal with both stages full. The pipeline advances in place.

Test Plan:
- I-type: base=0x00000013, imm=0xFFFFF800, immsrc=000, out_ready=1 -> out_valid 2 cycles after accept, out_instr=0x80000013, out_err=0.
- B-type: base=0x00000063, imm=0xFFFFFFFE, immsrc=010 -> out_instr=0xFE000FE3, err=0. Same with imm=0x00000003 -> out_err=1, err_count=1.
- J and U: base=0x0000006F, imm=0x00000800, immsrc=011 -> 0x0010006F. Then base=0x00000037, imm=0x00001001, immsrc=100 -> out_instr=0x00001037, out_err=1.
- Backpressure:
  - Hold out_ready=0 and offer 3 back-to-back words -> exactly 2 accepted, in_ready=0 on the third, outputs held stable.
  - Release out_ready -> 3 words out in order, no duplicates.
  - Random out_ready/in_valid for 1000 words vs scoreboard -> full match.
- Reset mid-stream: assert reset with both stages valid and err_count=5 -> next cycle out_valid=0, err_count=0, in_ready=1. The dropped words never appear.
- Saturation/illegal: CNT_W=2, send 5 words with immsrc=111, base=0x12345678 -> each out_instr=0x12345678, out_err=1, err_count stops at 3. With CHECK_EN=0 -> out_err=0 and err_count=0 throughout.

Source files
------------

// File: rtl/imm_insert_encoder.sv
`default_nettype none
// ============================================================================
// Module      : imm_insert_encoder
// Description : Packs a 32-bit immediate into the immediate fields of an RV32I
//               instruction word. Two-stage valid/ready pipeline with a range
//               checker and a saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_insert_encoder #(
  parameter int CNT_W    = 16,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_immsrc,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] C_SRC_I = 3'b000;
  localparam logic [2:0] C_SRC_S = 3'b001;
  localparam logic [2:0] C_SRC_B = 3'b010;
  localparam logic [2:0] C_SRC_J = 3'b011;
  localparam logic [2:0] C_SRC_U = 3'b100;

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_immsrc_q, s1_immsrc_d;
  logic [31:0]      s1_imm_q, s1_imm_d;
  logic [31:0]      s1_base_q, s1_base_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_instr_q, s2_instr_d;
  logic             s2_err_q, s2_err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic             s1_en;
  logic             s2_en;
  logic             err1_raw;
  logic             err1;
  logic [31:0]      packed_instr;

  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  // An immediate fits when every bit above the field's sign bit matches it.
  always_comb begin
    err1_raw = 1'b0;
    case (s1_immsrc_q)
      C_SRC_I, C_SRC_S: err1_raw = !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
      C_SRC_B:          err1_raw = s1_imm_q[0] || !((&s1_imm_q[31:12]) || !(|s1_imm_q[31:12]));
      C_SRC_J:          err1_raw = s1_imm_q[0] || !((&s1_imm_q[31:20]) || !(|s1_imm_q[31:20]));
      C_SRC_U:          err1_raw = |s1_imm_q[11:0];
      default:          err1_raw = 1'b1;
    endcase
  end

  generate
    if (CHECK_EN) begin : g_check
      assign err1 = err1_raw;
    end else begin : g_no_check
      assign err1 = 1'b0;
    end
  endgenerate

  always_comb begin
    packed_instr = s1_base_q;
    case (s1_immsrc_q)
      C_SRC_I: packed_instr[31:20] = s1_imm_q[11:0];
      C_SRC_S: begin
        packed_instr[31:25] = s1_imm_q[11:5];
        packed_instr[11:7]  = s1_imm_q[4:0];
      end
      C_SRC_B: begin
        packed_instr[31]    = s1_imm_q[12];
        packed_instr[7]     = s1_imm_q[11];
        packed_instr[30:25] = s1_imm_q[10:5];
        packed_instr[11:8]  = s1_imm_q[4:1];
      end
      C_SRC_J: begin
        packed_instr[31]    = s1_imm_q[20];
        packed_instr[30:21] = s1_imm_q[10:1];
        packed_instr[20]    = s1_imm_q[11];
        packed_instr[19:12] = s1_imm_q[19:12];
      end
      C_SRC_U: packed_instr[31:12] = s1_imm_q[31:12];
      default: packed_instr = s1_base_q;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_immsrc_d = s1_immsrc_q;
    s1_imm_d    = s1_imm_q;
    s1_base_d   = s1_base_q;
    s2_valid_d  = s2_valid_q;
    s2_instr_d  = s2_instr_q;
    s2_err_d    = s2_err_q;
    err_count_d = err_count_q;

    if (s1_en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_immsrc_d = in_immsrc;
        s1_imm_d    = in_imm;
        s1_base_d   = in_base;
      end
    end

    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_d = packed_instr;
        s2_err_d   = err1;
      end
    end

    // Counts delivered errored words; sticks at all-ones.
    if (s2_valid_q && out_ready && s2_err_q && !(&err_count_q)) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_immsrc_q <= 3'b000;
      s1_imm_q    <= 32'h0;
      s1_base_q   <= 32'h0;
      s2_valid_q  <= 1'b0;
      s2_instr_q  <= 32'h0;
      s2_err_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_immsrc_q <= s1_immsrc_d;
      s1_imm_q    <= s1_imm_d;
      s1_base_q   <= s1_base_d;
      s2_valid_q  <= s2_valid_d;
      s2_instr_q  <= s2_instr_d;
      s2_err_q    <= s2_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_insert_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_insert_encoder
// Description : Scoreboard bench for imm_insert_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_insert_encoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [2:0]  in_immsrc;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_ready;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr;
  logic [15:0] err_count;

  logic        s_in_ready, s_out_valid, s_out_err;
  logic [31:0] s_out_instr;
  logic [1:0]  s_err_count;

  logic        n_in_ready, n_out_valid, n_out_err;
  logic [31:0] n_out_instr;
  logic [15:0] n_err_count;

  int          checks;
  int          failures;
  int          or_mode;
  bit          aux_on;
  logic [32:0] q[$];
  logic [15:0] mcnt;
  logic [1:0]  acnt;

  imm_insert_encoder #(.CNT_W(16), .CHECK_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_immsrc(in_immsrc), .in_imm(in_imm), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_count(err_count)
  );

  imm_insert_encoder #(.CNT_W(2), .CHECK_EN(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_immsrc(in_immsrc), .in_imm(in_imm), .in_base(in_base),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
    .out_err(s_out_err), .err_count(s_err_count)
  );

  imm_insert_encoder #(.CNT_W(16), .CHECK_EN(1'b0)) dut_nochk (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_immsrc(in_immsrc), .in_imm(in_imm), .in_base(in_base),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_instr(n_out_instr),
    .out_err(n_out_err), .err_count(n_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference encoder expressed as numeric ranges: returns {err, instr}.
  function automatic logic [32:0] model(input logic [2:0] src, input logic [31:0] imm,
                                        input logic [31:0] base);
    logic [31:0] w;
    logic        e;
    int          v;
    w = base;
    v = $signed(imm);
    e = 1'b1;
    case (src)
      3'd0: begin w = {imm[11:0], base[19:0]}; e = (v < -2048) || (v > 2047); end
      3'd1: begin
        w = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        e = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        w = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        e = (v < -4096) || (v > 4095) || imm[0];
      end
      3'd3: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        e = (v < -1048576) || (v > 1048575) || imm[0];
      end
      3'd4: begin w = {imm[31:12], base[11:0]}; e = (imm[11:0] != 12'h0); end
      default: begin w = base; e = 1'b1; end
    endcase
    return {e, w};
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base,
                      input logic [32:0] exp);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_immsrc = src;
    in_imm    = imm;
    in_base   = base;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) break;
    end
    if (n > 300) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 300 cycles");
    end else begin
      q.push_back(exp);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
  endtask

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Main scoreboard monitor: a word transfers on the posedge after a negedge with valid&&ready.
  initial begin
    logic [32:0] e;
    mcnt = 16'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mcnt = 16'h0;
      end else if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got instr 0x%08h expected no output", out_instr);
        end else begin
          e = q.pop_front();
          chk("out_instr", out_instr, e[31:0]);
          chk("out_err", {31'h0, out_err}, {31'h0, e[32]});
          chk("err_count", {16'h0, err_count}, {16'h0, mcnt});
          if (e[32] && mcnt != 16'hFFFF) mcnt = mcnt + 16'h1;
        end
      end
    end
  end

  // Monitor for the narrow-counter and checking-disabled instances.
  initial begin
    acnt = 2'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        acnt = 2'h0;
      end else if (aux_on && out_ready) begin
        chk("sat_valid", {31'h0, s_out_valid}, {31'h0, n_out_valid});
        if (s_out_valid) begin
          chk("sat_instr", s_out_instr, 32'h12345678);
          chk("sat_err", {31'h0, s_out_err}, 32'h1);
          chk("sat_count", {30'h0, s_err_count}, {30'h0, acnt});
          if (acnt != 2'h3) acnt = acnt + 2'h1;
        end
        if (n_out_valid) begin
          chk("nochk_instr", n_out_instr, 32'h12345678);
          chk("nochk_err", {31'h0, n_out_err}, 32'h0);
          chk("nochk_count", {16'h0, n_err_count}, 32'h0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    logic [2:0]  src;
    logic [31:0] imm, base;
    int          k;
    checks    = 0;
    failures  = 0;
    or_mode   = 0;
    aux_on    = 1'b0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_immsrc = 3'b000;
    in_imm    = 32'h0;
    in_base   = 32'h0;
    cycles(3);
    reset = 1'b0;

    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_err", {31'h0, out_err}, 32'h0);
    chk("rst_err_count", {16'h0, err_count}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

    or_mode = 1;
    cycles(2);
    send(3'b000, 32'hFFFFF800, 32'h00000013, {1'b0, 32'h80000013});
    chk("lat_cycle1", {31'h0, out_valid}, 32'h0);
    cycles(1);
    chk("lat_cycle2", {31'h0, out_valid}, 32'h1);
    send(3'b010, 32'hFFFFFFFE, 32'h00000063, {1'b0, 32'hFE000FE3});
    send(3'b010, 32'h00000003, 32'h00000063, {1'b1, 32'h00000163});
    send(3'b011, 32'h00000800, 32'h0000006F, {1'b0, 32'h0010006F});
    send(3'b100, 32'h00001001, 32'h00000037, {1'b1, 32'h00001037});
    send(3'b001, 32'hFFFFFFF5, 32'h00002023, {1'b0, 32'hFE002AA3});
    drain();
    chk("dir_err_count", {16'h0, err_count}, 32'h2);

    // Backpressure: two words fill the pipe, the third is refused.
    or_mode = 0;
    cycles(2);
    in_valid = 1'b1; in_immsrc = 3'b000; in_imm = 32'h1; in_base = 32'h13;
    @(negedge clk);
    chk("bp_accept1", {31'h0, in_ready}, 32'h1);
    q.push_back({1'b0, 32'h00100013});
    @(posedge clk); #1;
    in_imm = 32'h2;
    @(negedge clk);
    chk("bp_accept2", {31'h0, in_ready}, 32'h1);
    q.push_back({1'b0, 32'h00200013});
    @(posedge clk); #1;
    in_imm = 32'h3;
    held = out_instr;
    chk("bp_head", held, 32'h00100013);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_blocked", {31'h0, in_ready}, 32'h0);
      chk("bp_held_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_held_instr", out_instr, 32'h00100013);
      @(posedge clk); #1;
    end
    or_mode = 1;
    send(3'b000, 32'h3, 32'h13, {1'b0, 32'h00300013});
    drain();

    // Randomised traffic against the reference model.
    or_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      cycles($urandom_range(0, 2));
      src  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      base = $urandom;
      imm  = $urandom;
      k    = $urandom_range(0, 3);
      if (k == 1) imm = {{20{imm[11]}}, imm[11:0]};
      if (k == 2) imm = {{19{imm[12]}}, imm[12:1], 1'b0};
      if (k == 3) imm = {{11{imm[20]}}, imm[20:1], 1'b0};
      send(src, imm, base, model(src, imm, base));
    end
    or_mode = 1;
    drain();

    // Reset with both stages occupied and a non-zero counter.
    pulse_reset();
    for (int i = 0; i < 5; i++) send(3'b101, 32'h0, 32'h00000033, {1'b1, 32'h00000033});
    drain();
    chk("pre_rst_count", {16'h0, err_count}, 32'h5);
    or_mode = 0;
    cycles(2);
    send(3'b000, 32'h7, 32'h13, {1'b0, 32'h00700013});
    send(3'b000, 32'h8, 32'h13, {1'b0, 32'h00800013});
    chk("pre_rst_full", {31'h0, out_valid}, 32'h1);
    pulse_reset();
    chk("post_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("post_rst_count", {16'h0, err_count}, 32'h0);
    chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
    or_mode = 1;
    cycles(6);

    // Saturation on a 2-bit counter and checking disabled.
    pulse_reset();
    aux_on = 1'b1;
    for (int i = 0; i < 5; i++) send(3'b111, 32'h0, 32'h12345678, {1'b1, 32'h12345678});
    drain();
    cycles(2);
    aux_on = 1'b0;
    chk("sat_final", {30'h0, s_err_count}, 32'h3);
    chk("nochk_final", {16'h0, n_err_count}, 32'h0);
    chk("main_final", {16'h0, err_count}, 32'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
